// File: rtl/jtdsp16_pio_pkg.sv
// rtl/jtdsp16_pio_pkg.sv - shared constants for the jtdsp16 parallel I/O host responder
package jtdsp16_pio_pkg;
    localparam int ST_TXNE    = 0;
    localparam int ST_RXFULL  = 1;
    localparam int ST_UDF     = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    localparam logic PSEL_DATA = 1'b0;
endpackage

// File: rtl/jtdsp16_pio_fifo.sv
// rtl/jtdsp16_pio_fifo.sv - 16-bit FIFO of 2**AW words with occupancy count
module jtdsp16_pio_fifo #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [15:0]   din,
    output logic [15:0]   dout,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [15:0]   mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = count[AW];
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/jtdsp16_pio_host.sv
// rtl/jtdsp16_pio_host.sv - host responder for the jtdsp16 parallel I/O port
// Optional JTDSP16_PIO_SYNC_EN: two-flop synchronizers on pods_n, pids_n, psel.
module jtdsp16_pio_host
    import jtdsp16_pio_pkg::*;
#(
    parameter int AW = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pbus_out,
    input  logic        pods_n,
    input  logic        pids_n,
    input  logic        psel,
    output logic [15:0] pbus_in,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [15:0] dsp_cmd,
    output logic        cmd_stb,
    output logic        ovf,
    output logic        udf
);
    logic pods_s, pids_s, psel_s;
    logic pods_l, pids_l;
    logic wev, rev;

`ifdef JTDSP16_PIO_SYNC_EN
    logic [1:0] pods_sy, pids_sy, psel_sy;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pods_sy <= 2'b11;
            pids_sy <= 2'b11;
            psel_sy <= 2'b00;
        end else begin
            pods_sy <= {pods_sy[0], pods_n};
            pids_sy <= {pids_sy[0], pids_n};
            psel_sy <= {psel_sy[0], psel};
        end
    end
    assign pods_s = pods_sy[1];
    assign pids_s = pids_sy[1];
    assign psel_s = psel_sy[1];
`else
    assign pods_s = pods_n;
    assign pids_s = pids_n;
    assign psel_s = psel;
`endif

    // History resets high so a strobe held low through reset yields no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pods_l <= 1'b1;
            pids_l <= 1'b1;
        end else begin
            pods_l <= pods_s;
            pids_l <= pids_s;
        end
    end
    assign wev = pods_s & ~pods_l;
    assign rev = pids_s & ~pids_l;

    logic [AW:0]  rx_count, tx_count;
    logic         rx_empty, tx_empty, rx_full, tx_full;
    logic [15:0]  tx_head;
    logic         rx_push, tx_push, tx_pop;
    logic         set_ovf, set_udf, clr_flags;

    assign rx_full  = rx_count[AW];
    assign tx_full  = tx_count[AW];
    assign rx_valid = ~rx_empty;
    assign tx_ready = ~tx_full;
    assign rx_push  = wev & (psel_s == PSEL_DATA);
    assign tx_push  = tx_valid & ~tx_full;
    assign tx_pop   = rev & (psel_s == PSEL_DATA) & ~tx_empty;
    assign set_ovf  = rx_push & rx_full & ~rx_ready;
    assign set_udf  = rev & (psel_s == PSEL_DATA) & tx_empty;
    assign clr_flags = rev & (psel_s != PSEL_DATA);

    jtdsp16_pio_fifo #(.AW(AW)) u_rx (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_ready),
        .din   (pbus_out),
        .dout  (rx_data),
        .empty (rx_empty),
        .count (rx_count)
    );

    jtdsp16_pio_fifo #(.AW(AW)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (tx_data),
        .dout  (tx_head),
        .empty (tx_empty),
        .count (tx_count)
    );

    logic [15:0] status;
    always_comb begin
        status                    = '0;
        status[15:ST_CNT_LSB]     = 12'(tx_count);
        status[ST_OVF]            = ovf;
        status[ST_UDF]            = udf;
        status[ST_RXFULL]         = rx_full;
        status[ST_TXNE]           = ~tx_empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dsp_cmd <= '0;
            cmd_stb <= 1'b0;
            ovf     <= 1'b0;
            udf     <= 1'b0;
            pbus_in <= '0;
        end else begin
            cmd_stb <= wev & (psel_s != PSEL_DATA);
            if (wev && psel_s != PSEL_DATA) dsp_cmd <= pbus_out;
            // Setting a flag takes priority over a status-read clear.
            if (set_ovf)        ovf <= 1'b1;
            else if (clr_flags) ovf <= 1'b0;
            if (set_udf)        udf <= 1'b1;
            else if (clr_flags) udf <= 1'b0;
            if (psel_s != PSEL_DATA) pbus_in <= status;
            else                     pbus_in <= tx_empty ? 16'h0000 : tx_head;
        end
    end
endmodule

// File: tb/tb_jtdsp16_pio_host.sv
// tb/tb_jtdsp16_pio_host.sv - self-checking bench for jtdsp16_pio_host
module tb_jtdsp16_pio_host;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pbus_out;
    logic        pods_n, pids_n, psel;
    logic [15:0] pbus_in;
    logic [15:0] rx_data;
    logic        rx_valid, rx_ready;
    logic [15:0] tx_data;
    logic        tx_valid, tx_ready;
    logic [15:0] dsp_cmd;
    logic        cmd_stb, ovf, udf;

    jtdsp16_pio_host #(.AW(3)) dut (
        .clk(clk), .rst(rst), .pbus_out(pbus_out), .pods_n(pods_n), .pids_n(pids_n),
        .psel(psel), .pbus_in(pbus_in), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .dsp_cmd(dsp_cmd), .cmd_stb(cmd_stb), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: two word queues, sticky flags, last command.
    logic [15:0] rx_q[$];
    logic [15:0] tx_q[$];
    logic        m_ovf, m_udf;
    logic [15:0] m_cmd;
    localparam int DEPTH = 8;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_status();
        logic [11:0] cnt;
        cnt = 12'(tx_q.size());
        return {cnt, m_ovf, m_udf, rx_q.size() == DEPTH, tx_q.size() != 0};
    endfunction

    task automatic m_reset();
        rx_q.delete();
        tx_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_cmd = 16'h0000;
    endtask

    task automatic dsp_write(input logic p, input logic [15:0] d);
        psel = p;
        pbus_out = d;
        pods_n = 1'b0;
        cyc();
        pods_n = 1'b1;
        cyc();
        if (!p) begin
            if (rx_q.size() < DEPTH) rx_q.push_back(d);
            else m_ovf = 1'b1;
        end else m_cmd = d;
        chk("cmd_stb_on", cmd_stb, p);
        chk("dsp_cmd", dsp_cmd, m_cmd);
        chk("rx_valid_w", rx_valid, rx_q.size() != 0);
        chk("ovf_w", ovf, m_ovf);
        cyc();
        chk("cmd_stb_off", cmd_stb, 1'b0);
    endtask

    task automatic dsp_read(input logic p, output logic [15:0] got);
        logic [15:0] exp;
        psel = p;
        cyc();
        pids_n = 1'b0;
        cyc();
        got = pbus_in;
        if (p) exp = m_status();
        else   exp = (tx_q.size() == 0) ? 16'h0000 : tx_q[0];
        chk(p ? "status" : "pbus_in", got, exp);
        pids_n = 1'b1;
        cyc();
        if (!p) begin
            if (tx_q.size() != 0) void'(tx_q.pop_front());
            else m_udf = 1'b1;
        end else begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        cyc();
        chk("ovf_r", ovf, m_ovf);
        chk("udf_r", udf, m_udf);
    endtask

    task automatic host_push(input logic [15:0] d);
        chk("tx_ready", tx_ready, tx_q.size() < DEPTH);
        tx_valid = 1'b1;
        tx_data = d;
        cyc();
        tx_valid = 1'b0;
        if (tx_q.size() < DEPTH) tx_q.push_back(d);
    endtask

    task automatic host_pop();
        chk("rx_valid_p", rx_valid, rx_q.size() != 0);
        if (rx_q.size() != 0) chk("rx_data", rx_data, rx_q[0]);
        rx_ready = 1'b1;
        cyc();
        rx_ready = 1'b0;
        if (rx_q.size() != 0) void'(rx_q.pop_front());
        chk("rx_valid_a", rx_valid, rx_q.size() != 0);
    endtask

    initial begin
        logic [15:0] got;
        logic [15:0] d;
        rst = 1'b1;
        pbus_out = '0; pods_n = 1'b1; pids_n = 1'b1; psel = 1'b0;
        rx_ready = 1'b0; tx_data = '0; tx_valid = 1'b0;
        m_reset();
        cyc(); cyc();
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_pbus_in", pbus_in, 16'h0000);
        chk("rst_flags", {ovf, udf, cmd_stb}, 3'b000);
        rst = 1'b0;
        cyc();

        // TX path: two host words read back by the DSP, status tracks count
        host_push(16'hBEEF);
        host_push(16'hBEF0);
        dsp_read(1'b0, got);
        chk("first_word", got, 16'hBEEF);
        dsp_read(1'b1, got);
        chk("status_one", got, 16'h0011);
        dsp_read(1'b0, got);
        chk("second_word", got, 16'hBEF0);
        dsp_read(1'b1, got);
        chk("status_zero", got, 16'h0000);

        // RX path single word
        dsp_write(1'b0, 16'h1234);
        chk("rx_head", rx_data, 16'h1234);
        host_pop();

        // Overflow: ninth write dropped
        for (int i = 0; i < 9; i++) dsp_write(1'b0, 16'(i));
        chk("ovf_set", ovf, 1'b1);
        dsp_read(1'b1, got);
        chk("status_ovf_bit", got[3], 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("drain_val", rx_data, 16'(i));
            host_pop();
        end

        // Underflow with same-cycle host push
        d = 16'($urandom);
        psel = 1'b0;
        cyc();
        pids_n = 1'b0;
        cyc();
        chk("udf_pbus_in", pbus_in, 16'h0000);
        pids_n = 1'b1;
        tx_valid = 1'b1;
        tx_data = d;
        cyc();
        tx_valid = 1'b0;
        m_udf = 1'b1;
        tx_q.push_back(d);
        chk("udf_set", udf, 1'b1);
        cyc();
        dsp_read(1'b1, got);
        chk("udf_txcnt", got[15:4], 12'd1);
        dsp_read(1'b0, got);

        // Command write
        dsp_write(1'b1, 16'h00A5);
        chk("cmd_rx_untouched", rx_valid, 1'b0);

        // RX full with same-cycle host pop: push accepted, no overflow
        for (int i = 0; i < 8; i++) dsp_write(1'b0, 16'($urandom));
        d = 16'($urandom);
        psel = 1'b0;
        pbus_out = d;
        pods_n = 1'b0;
        cyc();
        pods_n = 1'b1;
        rx_ready = 1'b1;
        cyc();
        rx_ready = 1'b0;
        void'(rx_q.pop_front());
        rx_q.push_back(d);
        chk("full_pop_ovf", ovf, 1'b0);
        cyc();
        for (int i = 0; i < 8; i++) host_pop();

        // Randomized mix of DSP and host operations
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0: dsp_write(1'b0, 16'($urandom));
                1: dsp_write(1'b1, 16'($urandom));
                2: dsp_read(1'b0, got);
                3: dsp_read(1'b1, got);
                4: host_push(16'($urandom));
                default: host_pop();
            endcase
        end

        // Reset mid-transfer with pods_n held low
        while (rx_q.size() != 0) host_pop();
        for (int i = 0; i < 3; i++) dsp_write(1'b0, 16'($urandom));
        dsp_write(1'b1, 16'h5A5A);
        d = 16'($urandom);
        psel = 1'b0;
        pbus_out = d;
        pods_n = 1'b0;
        cyc();
        #2 rst = 1'b1;
        #1;
        m_reset();
        chk("mid_rx_valid", rx_valid, 1'b0);
        chk("mid_tx_ready", tx_ready, 1'b1);
        chk("mid_dsp_cmd", dsp_cmd, 16'h0000);
        chk("mid_pbus_in", pbus_in, 16'h0000);
        chk("mid_flags", {ovf, udf, cmd_stb}, 3'b000);
        cyc();
        rst = 1'b0;
        cyc(); cyc();
        chk("no_edge_release", rx_valid, 1'b0);
        pods_n = 1'b1;
        cyc();
        rx_q.push_back(d);
        chk("one_event_valid", rx_valid, 1'b1);
        cyc(); cyc();
        host_pop();
        chk("one_event_only", rx_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
